// File: rtl/binary_pkg.sv
// Shared types and helpers for the binary primitives library (add/mul/div).
package binary_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_e;

    // Iteration counter width; must hold WIDTH-1.
    function automatic int cnt_w(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract iteration: shift in the dividend msb, subtract
// the divisor when it fits.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] partial_i,
    input  logic             msb_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] partial_o,
    output logic             qbit_o
);

    logic [WIDTH:0] shifted;

    // Compare at WIDTH+1 bits; the difference always fits back into WIDTH bits.
    assign shifted   = {partial_i, msb_i};
    assign qbit_o    = (shifted >= {1'b0, divisor_i});
    assign partial_o = qbit_o ? (shifted[WIDTH-1:0] - divisor_i) : shifted[WIDTH-1:0];

endmodule

// File: rtl/div_seq.sv
// Fixed-latency unsigned restoring divider: one quotient bit per cycle,
// done pulses WIDTH+1 cycles after an accepted go.
module div_seq
    import binary_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             go,
    input  logic [WIDTH-1:0] left,
    input  logic [WIDTH-1:0] right,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output div_state_e       dbg_state
);

    localparam int CNT_W = cnt_w(WIDTH);

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dsr_q, dsr_d;
    logic [WIDTH-1:0] part_q, part_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;

    logic [WIDTH-1:0] step_part;
    logic             step_qbit;

    div_step #(.WIDTH(WIDTH)) u_step (
        .partial_i (part_q),
        .msb_i     (dvd_q[WIDTH-1]),
        .divisor_i (dsr_q),
        .partial_o (step_part),
        .qbit_o    (step_qbit)
    );

    // Handshake: go is accepted on any edge where ready is high (IDLE or DONE);
    // a go seen while BUSY is dropped without sampling the operands.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dvd_d   = dvd_q;
        dsr_d   = dsr_q;
        part_d  = part_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        case (state_q)
            IDLE, DONE: begin
                if (go) begin
                    dvd_d   = left;
                    dsr_d   = right;
                    part_d  = '0;
                    cnt_d   = CNT_W'(WIDTH - 1);
                    state_d = BUSY;
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                // Dividend register doubles as the quotient shift register.
                part_d = step_part;
                dvd_d  = {dvd_q[WIDTH-2:0], step_qbit};
                if (cnt_q == '0) begin
                    quo_d   = {dvd_q[WIDTH-2:0], step_qbit};
                    rem_d   = step_part;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dvd_q   <= '0;
            dsr_q   <= '0;
            part_q  <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dvd_q   <= dvd_d;
            dsr_q   <= dsr_d;
            part_q  <= part_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
        end
    end

    assign ready     = (state_q != BUSY);
    assign done      = (state_q == DONE);
    assign quotient  = quo_q;
    assign remainder = rem_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_div_seq.sv
// Randomized bench for div_seq at WIDTH=32 and WIDTH=8 against an arithmetic model.
module tb_div_seq;
    import binary_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        go32, go8;
    logic [31:0] l32, r32, q32, rm32;
    logic [7:0]  l8, r8, q8, rm8;
    logic        rdy32, dn32, rdy8, dn8;
    div_state_e  st32, st8;

    int n_cmp = 0;
    int n_err = 0;

    div_seq #(.WIDTH(32)) u_dut32 (
        .clk(clk), .reset(reset), .go(go32), .left(l32), .right(r32),
        .ready(rdy32), .done(dn32), .quotient(q32), .remainder(rm32), .dbg_state(st32)
    );

    div_seq #(.WIDTH(8)) u_dut8 (
        .clk(clk), .reset(reset), .go(go8), .left(l8), .right(r8),
        .ready(rdy8), .done(dn8), .quotient(q8), .remainder(rm8), .dbg_state(st8)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain unsigned division; divide by zero gives all ones / dividend.
    function automatic logic [63:0] ref_div(input bit sel8, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] mask;
        logic [31:0] am, bm;
        mask = sel8 ? 32'h0000_00FF : 32'hFFFF_FFFF;
        am = a & mask;
        bm = b & mask;
        if (bm == 0) return {mask, am};
        return {am / bm, am % bm};
    endfunction

    function automatic logic f_done(input bit sel8);
        return sel8 ? dn8 : dn32;
    endfunction
    function automatic logic f_ready(input bit sel8);
        return sel8 ? rdy8 : rdy32;
    endfunction
    function automatic logic [31:0] f_q(input bit sel8);
        return sel8 ? {24'd0, q8} : q32;
    endfunction
    function automatic logic [31:0] f_r(input bit sel8);
        return sel8 ? {24'd0, rm8} : rm32;
    endfunction

    task automatic drive(input bit sel8, input logic g, input logic [31:0] a, input logic [31:0] b);
        if (sel8) begin
            go8 = g; l8 = a[7:0]; r8 = b[7:0];
        end else begin
            go32 = g; l32 = a; r32 = b;
        end
    endtask

    // Call between a negedge and the following posedge. Returns at the negedge
    // of the done cycle (lat = cycles after the go edge), or lat=-1 on timeout.
    task automatic run_op(input bit sel8, input logic [31:0] a, input logic [31:0] b,
                          input bit hold, input int inj_a, input int inj_b, input int rst_at,
                          output int lat, output int busy);
        lat  = -1;
        busy = 0;
        drive(sel8, 1'b1, a, b);
        @(posedge clk);
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (k == rst_at + 1) begin
                check_val("rst_mid_ready", {31'd0, f_ready(sel8)}, 32'd1);
                check_val("rst_mid_done", {31'd0, f_done(sel8)}, 32'd0);
                check_val("rst_mid_quot", f_q(sel8), 32'd0);
                check_val("rst_mid_rem", f_r(sel8), 32'd0);
            end
            if (f_done(sel8)) begin
                lat = k;
                check_val("done_ready", {31'd0, f_ready(sel8)}, 32'd1);
                break;
            end
            if (!f_ready(sel8)) busy++;
            reset = (k == rst_at) ? 1'b0 : 1'b1;
            if (k == inj_a || k == inj_b) drive(sel8, 1'b1, $urandom, $urandom);
            else drive(sel8, hold, a, b);
        end
    endtask

    task automatic verify(input string tag, input bit sel8, input logic [31:0] a,
                          input logic [31:0] b, input int lat, input int busy);
        logic [63:0] exp;
        exp = ref_div(sel8, a, b);
        check_val({tag, "_lat"}, lat, sel8 ? 32'd9 : 32'd33);
        check_val({tag, "_busy"}, busy, sel8 ? 32'd8 : 32'd32);
        check_val({tag, "_quot"}, f_q(sel8), exp[63:32]);
        check_val({tag, "_rem"}, f_r(sel8), exp[31:0]);
    endtask

    initial begin
        int lat, busy;
        logic [31:0] a, b;
        bit sel8;

        reset = 1'b0;
        drive(1'b0, 1'b0, 32'd0, 32'd0);
        drive(1'b1, 1'b0, 32'd0, 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_ready32", {31'd0, rdy32}, 32'd1);
        check_val("rst_done32", {31'd0, dn32}, 32'd0);
        check_val("rst_quot32", q32, 32'd0);
        check_val("rst_rem32", rm32, 32'd0);
        check_val("rst_ready8", {31'd0, rdy8}, 32'd1);
        reset = 1'b1;

        run_op(1'b0, 32'd100, 32'd7, 1'b0, -1, -1, -5, lat, busy);
        verify("d100_7", 1'b0, 32'd100, 32'd7, lat, busy);
        @(negedge clk);
        check_val("done_one_cycle", {31'd0, dn32}, 32'd0);
        check_val("idle_ready", {31'd0, rdy32}, 32'd1);

        run_op(1'b0, 32'd5, 32'd0, 1'b0, -1, -1, -5, lat, busy);
        verify("div0", 1'b0, 32'd5, 32'd0, lat, busy);
        @(negedge clk);
        run_op(1'b0, 32'hFFFF_FFFF, 32'd1, 1'b0, -1, -1, -5, lat, busy);
        verify("max_1", 1'b0, 32'hFFFF_FFFF, 32'd1, lat, busy);
        @(negedge clk);
        run_op(1'b0, 32'd3, 32'd10, 1'b0, -1, -1, -5, lat, busy);
        verify("small", 1'b0, 32'd3, 32'd10, lat, busy);
        @(negedge clk);

        run_op(1'b0, 32'd100, 32'd7, 1'b0, 5, 20, -5, lat, busy);
        verify("go_ignored", 1'b0, 32'd100, 32'd7, lat, busy);
        @(negedge clk);

        run_op(1'b0, 32'd100, 32'd7, 1'b0, -1, -1, 10, lat, busy);
        check_val("rst_no_done", lat, 32'hFFFF_FFFF);
        check_val("rst_hold_quot", q32, 32'd0);
        @(negedge clk);

        run_op(1'b0, 32'd1000, 32'd10, 1'b1, -1, -1, -5, lat, busy);
        verify("b2b_first", 1'b0, 32'd1000, 32'd10, lat, busy);
        run_op(1'b0, 32'd81, 32'd9, 1'b0, -1, -1, -5, lat, busy);
        verify("b2b_second", 1'b0, 32'd81, 32'd9, lat, busy);
        @(negedge clk);

        run_op(1'b1, 32'd200, 32'd3, 1'b0, -1, -1, -5, lat, busy);
        verify("w8_200_3", 1'b1, 32'd200, 32'd3, lat, busy);
        @(negedge clk);

        for (int i = 0; i < 40; i++) begin
            sel8 = (i >= 28);
            a = $urandom;
            case ($urandom_range(0, 3))
                0: b = 32'd0;
                1: b = $urandom_range(1, 15);
                2: b = $urandom;
                default: b = sel8 ? {24'd0, a[7:0]} + $urandom_range(1, 20) : a + $urandom_range(1, 20);
            endcase
            run_op(sel8, a, b, 1'b0, -1, -1, -5, lat, busy);
            verify(sel8 ? "rand8" : "rand32", sel8, a, b, lat, busy);
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(1, 3)) @(negedge clk);
            end
        end
        drive(1'b0, 1'b0, 32'd0, 32'd0);
        drive(1'b1, 1'b0, 32'd0, 32'd0);
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
